// File: rtl/alu_pipe.sv
// Pipelined ALU: single-cycle ops plus an optional iterative shift-add multiplier.
// Define ALU_PIPE_MUL_EN to build the multiplier; otherwise opcode 10 reports illegal.
module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             negative,
  output logic             overflow,
  output logic             illegal
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, HOLD = 2'd2} state_t;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d, carry_q, carry_d, negative_q, negative_d;
  logic             overflow_q, overflow_d, illegal_q, illegal_d;

  logic             accept;
  logic             is_mul;
  logic [SW-1:0]    s;
  logic [WIDTH:0]   sum, diff, shl_full, shr_full, asr_full;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_ill;

`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;
  logic [WIDTH-1:0] mcand_q, mcand_d, prod_hi_q, prod_hi_d, prod_lo_q, prod_lo_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  assign is_mul    = (opcode == 4'd10);
  assign result_hi = result_hi_q;
`else
  assign is_mul    = 1'b0;
  assign result_hi = '0;
`endif

  assign s = b[SW-1:0];

  // Shifts are done one bit wider so the last bit shifted out falls into the spare bit.
  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    diff     = {1'b0, a} - {1'b0, b};
    shl_full = {1'b0, a} << s;
    shr_full = {a, 1'b0} >> s;
    asr_full = $signed({a, 1'b0}) >>> s;
    alu_res  = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    alu_ill  = 1'b0;
    case (opcode)
      4'd0: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: alu_res = a & b;
      4'd3: alu_res = a | b;
      4'd4: alu_res = a ^ b;
      4'd5: alu_res = b;
      4'd6: alu_res = a;
      4'd7: begin
        alu_res = shl_full[WIDTH-1:0];
        alu_c   = shl_full[WIDTH];
      end
      4'd8: begin
        alu_res = shr_full[WIDTH:1];
        alu_c   = shr_full[0];
      end
      4'd9: begin
        alu_res = asr_full[WIDTH:1];
        alu_c   = asr_full[0];
      end
      default: begin
        alu_res = {{(WIDTH-1){1'b0}}, 1'b1};
        alu_ill = 1'b1;
      end
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  // Right-shifting shift-add: the multiplier drains out of prod_lo as the product fills in.
  always_comb begin
    mul_sum     = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : '0);
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], prod_lo_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    case (state_q)
      IDLE:    in_ready = 1'b1;
      HOLD:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    negative_d  = negative_q;
    overflow_d  = overflow_q;
    illegal_d   = illegal_q;
`ifdef ALU_PIPE_MUL_EN
    mcand_d     = mcand_q;
    prod_hi_d   = prod_hi_q;
    prod_lo_d   = prod_lo_q;
    cnt_d       = cnt_q;
    result_hi_d = result_hi_q;
`endif
    case (state_q)
      IDLE, HOLD: begin
        if (accept && is_mul) begin
          state_d     = MUL;
          out_valid_d = 1'b0;
`ifdef ALU_PIPE_MUL_EN
          mcand_d     = a;
          prod_hi_d   = '0;
          prod_lo_d   = b;
          cnt_d       = '0;
`endif
        end else if (accept) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          result_d    = alu_res;
          zero_d      = ~|alu_res;
          carry_d     = alu_c;
          negative_d  = alu_res[WIDTH-1];
          overflow_d  = alu_v;
          illegal_d   = alu_ill;
`ifdef ALU_PIPE_MUL_EN
          result_hi_d = '0;
`endif
        end else if (state_q == HOLD && out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end
      end
      MUL: begin
`ifdef ALU_PIPE_MUL_EN
        prod_hi_d = mul_hi_next;
        prod_lo_d = mul_lo_next;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          result_d    = mul_lo_next;
          result_hi_d = mul_hi_next;
          zero_d      = ~|mul_lo_next;
          carry_d     = |mul_hi_next;
          negative_d  = mul_lo_next[WIDTH-1];
          overflow_d  = 1'b0;
          illegal_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`else
        state_d     = IDLE;
        out_valid_d = 1'b0;
`endif
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      negative_q  <= 1'b0;
      overflow_q  <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mcand_q     <= '0;
      prod_hi_q   <= '0;
      prod_lo_q   <= '0;
      cnt_q       <= '0;
      result_hi_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      negative_q  <= negative_d;
      overflow_q  <= overflow_d;
      illegal_q   <= illegal_d;
`ifdef ALU_PIPE_MUL_EN
      mcand_q     <= mcand_d;
      prod_hi_q   <= prod_hi_d;
      prod_lo_q   <= prod_lo_d;
      cnt_q       <= cnt_d;
      result_hi_q <= result_hi_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign negative  = negative_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;
endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; SHALL be legal for 4..64.
REQ-002 Ports SHALL be, clock and reset first:
  clk  input  1  single clock, all state on rising edge
  rst_n  input  1  reset, asynchronous assert, active-low
  in_valid  input  1  operation offered
  in_ready  output  1  operation accepted when in_valid & in_ready at clk rise
  opcode  input  4  operation select (REQ-006)
  a  input  WIDTH  operand A (accumulator side)
  b  input  WIDTH  operand B (data side)
  out_valid  output  1  result held and valid
  out_ready  input  1  consumer takes result when out_valid & out_ready
  result  output  WIDTH  low result
  result_hi  output  WIDTH  MUL high half, else 0
  zero/carry/negative/overflow  output  1 each  status flags of result
  illegal  output  1  accepted opcode was unsupported

Function
REQ-003 FSM states SHALL be IDLE, MUL, HOLD.
REQ-004 in_ready SHALL be 1 in IDLE, 0 in MUL, and equal to out_ready in HOLD.
REQ-005 Accept: IDLE/HOLD with in_valid & in_ready; single-cycle op -> result, flags, out_valid=1 next clk (state HOLD); MUL op -> state MUL.
REQ-006 Opcodes: 0 ADD a+b; 1 SUB a-b; 2 AND; 3 OR; 4 XOR; 5 LDB result=b; 6 LDA result=a; 7 SHL a<<s; 8 SHR logical a>>s; 9 ASR arithmetic a>>>s; 10 MUL unsigned a*b; s = b[clog2(WIDTH)-1:0].
REQ-007 Unsupported opcode SHALL complete as single-cycle op with result=1 (value one), result_hi=0, illegal=1, other flags from result.
REQ-008 Arithmetic SHALL be modulo 2^WIDTH; carry: ADD carry-out; SUB borrow (a<b unsigned); SHL/SHR/ASR last bit shifted out (0 if s=0); MUL |result_hi; else 0.
REQ-009 overflow SHALL be signed overflow for ADD/SUB, 0 otherwise; zero=(result==0, result_hi ignored); negative=result[WIDTH-1].
REQ-010 MUL SHALL be iterative shift-add, one bit per cycle, WIDTH iterations; out_valid rises exactly WIDTH+1 cycles after accept.
REQ-011 Operands/opcode SHALL be captured at accept; later input changes SHALL not affect in-flight op.
REQ-012 HOLD: result/flags SHALL stay stable while out_valid & !out_ready.
REQ-013 HOLD with out_ready & !in_valid -> IDLE, out_valid=0 next cycle; out_ready & in_valid -> new op accepted same cycle (single-cycle ops: one result per clk back-to-back).
REQ-014 Outputs other than in_ready SHALL be registered; in_ready SHALL be combinational only from state and out_ready.

Reset
REQ-015 rst_n low SHALL immediately force IDLE, out_valid=0, result=0, result_hi=0, all flags=0, MUL counter=0; in_ready=1 after release.
REQ-016 Reset during MUL or HOLD SHALL discard the op; no out_valid after release without new accept.

Configuration
REQ-017 Macro ALU_PIPE_MUL_EN: defined -> opcode 10 executes MUL per REQ-010; undefined -> no multiplier/MUL state logic synthesised, opcode 10 treated as unsupported per REQ-007, result_hi tied 0.

Verification
REQ-018 WIDTH=8: ADD a=8'hFF b=8'h01 -> next clk result=8'h00, zero=1, carry=1, overflow=0.
REQ-019 WIDTH=8: SUB a=8'h80 b=8'h01 -> result=8'h7F, overflow=1, carry=0, negative=0.
REQ-020 ALU_PIPE_MUL_EN, WIDTH=8: MUL a=8'hFF b=8'hFF -> in_ready=0 8 cycles, out_valid at cycle 9, result=8'h01, result_hi=8'hFE, carry=1; without macro -> next clk result=8'h01, illegal=1.
REQ-021 out_ready held 0 for 5 cycles after ADD 3+4 -> result=7 stable, in_ready=0; out_ready=1 with in_valid XOR 8'hF0^8'h0F -> next clk result=8'hFF, negative=1.
REQ-022 rst_n pulsed low mid-MUL (cycle 3) -> out_valid=0, result=0 immediately; no result emitted afterwards; in_ready=1 after release.
